// File: rtl/dmem_port_arbiter.sv
// Byte-wide data-memory port shared by the pipeline (P) and loader (L).
// Multi-byte requests are split into big-endian byte beats.
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        p_req,
  input  logic        l_req,
  input  logic        p_rw,
  input  logic        l_rw,
  input  logic [1:0]  p_size,
  input  logic [1:0]  l_size,
  input  logic [7:0]  p_addr,
  input  logic [7:0]  l_addr,
  input  logic [31:0] p_wdata,
  input  logic [31:0] l_wdata,
  output logic        p_done,
  output logic        l_done,
  output logic        p_err,
  output logic        l_err,
  output logic [31:0] p_rdata,
  output logic [31:0] l_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [7:0]  m_addr,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  logic        sel_l;
  logic        rw;
  logic [1:0]  last;
  logic [1:0]  beat;
  logic [31:0] wsh;
  logic [31:0] asm_q;
  logic [3:0]  starve_cnt;

  logic        l_win;
  logic        g_rw;
  logic [1:0]  g_size;
  logic [7:0]  g_addr;
  logic [31:0] g_wdata;
  logic        g_ok;
  logic [1:0]  g_last;
  logic [31:0] g_wl;
  logic [31:0] rd_next;
  logic [31:0] rd_fin;

  assign busy    = (state != IDLE);
  assign rd_next = {asm_q[23:0], m_rdata};
  assign rd_fin  = rw ? 32'd0 : rd_next;

  // g_wl holds the write data left-justified so beats peel off the top byte
  always_comb begin
    l_win   = l_req && (!p_req || starve_cnt == LIMIT);
    g_rw    = l_win ? l_rw    : p_rw;
    g_size  = l_win ? l_size  : p_size;
    g_addr  = l_win ? l_addr  : p_addr;
    g_wdata = l_win ? l_wdata : p_wdata;
    g_ok    = 1'b0;
    g_last  = 2'd0;
    g_wl    = g_wdata;
    case (g_size)
      2'b00: begin
        g_ok = 1'b1;
        g_wl = g_wdata << 24;
      end
      2'b10: begin
        g_ok   = !g_addr[0];
        g_last = 2'd1;
        g_wl   = g_wdata << 16;
      end
      2'b01: begin
        g_ok   = (g_addr[1:0] == 2'b00);
        g_last = 2'd3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      sel_l      <= 1'b0;
      rw         <= 1'b0;
      last       <= 2'd0;
      beat       <= 2'd0;
      wsh        <= 32'd0;
      asm_q      <= 32'd0;
      starve_cnt <= 4'd0;
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= 8'd0;
      m_wdata    <= 8'd0;
      p_done     <= 1'b0;
      l_done     <= 1'b0;
      p_err      <= 1'b0;
      l_err      <= 1'b0;
      p_rdata    <= 32'd0;
      l_rdata    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (p_req || l_req) begin
            sel_l <= l_win;
            rw    <= g_rw;
            last  <= g_last;
            beat  <= 2'd0;
            asm_q <= 32'd0;
            wsh   <= g_wl << 8;
            if (l_win)
              starve_cnt <= 4'd0;
            else if (l_req && starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + 4'd1;
            if (g_ok) begin
              state   <= XFER;
              m_en    <= 1'b1;
              m_we    <= g_rw;
              m_addr  <= g_addr;
              m_wdata <= g_wl[31:24];
            end else begin
              state  <= RESP;
              p_done <= !l_win;
              p_err  <= !l_win;
              l_done <= l_win;
              l_err  <= l_win;
              if (l_win) l_rdata <= 32'd0;
              else       p_rdata <= 32'd0;
            end
          end
        end
        XFER: begin
          if (!rw) asm_q <= rd_next;
          if (beat == last) begin
            state  <= RESP;
            m_en   <= 1'b0;
            m_we   <= 1'b0;
            p_done <= !sel_l;
            l_done <= sel_l;
            if (sel_l) l_rdata <= rd_fin;
            else       p_rdata <= rd_fin;
          end else begin
            beat    <= beat + 2'd1;
            m_addr  <= m_addr + 8'd1;
            m_wdata <= wsh[31:24];
            wsh     <= wsh << 8;
          end
        end
        RESP: begin
          state  <= IDLE;
          p_done <= 1'b0;
          l_done <= 1'b0;
          p_err  <= 1'b0;
          l_err  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: transaction-level timeline model,
// directed scenarios, then two random requesters.
module tb_dmem_port_arbiter;

  localparam int LIM = 4;

  logic        Clk, Reset;
  logic        p_req, l_req, p_rw, l_rw;
  logic [1:0]  p_size, l_size;
  logic [7:0]  p_addr, l_addr;
  logic [31:0] p_wdata, l_wdata;
  logic        p_done, l_done, p_err, l_err;
  logic [31:0] p_rdata, l_rdata;
  logic        m_en, m_we;
  logic [7:0]  m_addr, m_wdata, m_rdata;
  logic        busy;

  dmem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .Clk(Clk), .Reset(Reset),
    .p_req(p_req), .l_req(l_req), .p_rw(p_rw), .l_rw(l_rw),
    .p_size(p_size), .l_size(l_size),
    .p_addr(p_addr), .l_addr(l_addr),
    .p_wdata(p_wdata), .l_wdata(l_wdata),
    .p_done(p_done), .l_done(l_done), .p_err(p_err), .l_err(l_err),
    .p_rdata(p_rdata), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory the DUT drives
  logic [7:0] mem [256] = '{default: 8'h00};
  assign m_rdata = mem[m_addr];
  always @(posedge Clk) if (m_en && m_we) mem[m_addr] <= m_wdata;

  typedef struct {
    bit        en, we;
    bit [7:0]  addr, wdata;
    bit        pd, ld, er;
    bit [31:0] rd;
  } rec_t;

  rec_t       q[$];
  logic [7:0] model_mem [256] = '{default: 8'h00};
  int         starve = 0;
  bit         cur_idle = 1'b1;
  logic [31:0] exp_prd = 0, exp_lrd = 0;
  int         cyc = 0;
  int         checks = 0, failures = 0;

  string       lit_name [128];
  logic [31:0] lit_act [128], lit_exp [128];
  int          lit_posted = 0, lit_done = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, a, e);
    end
  endtask

  // Whole transaction laid out as a per-cycle timeline at acceptance
  task automatic accept();
    bit lw, rw, ok;
    bit [1:0] sz;
    int a, n;
    logic [31:0] wd, rd;
    rec_t r;
    lw = l_req && (!p_req || starve == LIM);
    if (lw) starve = 0;
    else if (l_req && starve < LIM) starve++;
    rw = lw ? l_rw : p_rw;
    sz = lw ? l_size : p_size;
    a  = lw ? int'(l_addr) : int'(p_addr);
    wd = lw ? l_wdata : p_wdata;
    n  = (sz == 2'b00) ? 1 : (sz == 2'b10) ? 2 : (sz == 2'b01) ? 4 : 0;
    ok = (n != 0) && (a % n == 0);
    rd = 0;
    if (ok) begin
      for (int b = 0; b < n; b++) begin
        r = '{default: 0};
        r.en = 1; r.we = rw;
        r.addr = 8'((a + b) % 256);
        r.wdata = 8'(wd >> (8 * (n - 1 - b)));
        q.push_back(r);
        if (!rw) rd = rd | (32'(model_mem[(a + b) % 256]) << (8 * (n - 1 - b)));
      end
    end
    r = '{default: 0};
    r.pd = !lw; r.ld = lw; r.er = !ok;
    r.rd = (ok && !rw) ? rd : 32'd0;
    q.push_back(r);
  endtask

  always begin
    rec_t r;
    @(posedge Clk);
    cyc++;
    if (Reset) begin
      q.delete();
      starve = 0;
      exp_prd = 0;
      exp_lrd = 0;
    end else if (cur_idle && (p_req || l_req)) begin
      accept();
    end
    @(negedge Clk);
    r = '{default: 0};
    cur_idle = (q.size() == 0);
    if (!cur_idle) r = q.pop_front();
    if (r.en && r.we) model_mem[r.addr] = r.wdata;
    if (r.pd) exp_prd = r.rd;
    if (r.ld) exp_lrd = r.rd;
    chk("m_en", 32'(m_en), 32'(r.en));
    chk("m_we", 32'(m_we), 32'(r.we));
    chk("busy", 32'(busy), 32'(!cur_idle));
    chk("p_done", 32'(p_done), 32'(r.pd));
    chk("l_done", 32'(l_done), 32'(r.ld));
    chk("p_err", 32'(p_err), 32'(r.pd && r.er));
    chk("l_err", 32'(l_err), 32'(r.ld && r.er));
    chk("p_rdata", p_rdata, exp_prd);
    chk("l_rdata", l_rdata, exp_lrd);
    if (r.en) begin
      chk("m_addr", 32'(m_addr), 32'(r.addr));
      chk("m_wdata", 32'(m_wdata), 32'(r.wdata));
    end
    while (lit_done < lit_posted) begin
      chk(lit_name[lit_done], lit_act[lit_done], lit_exp[lit_done]);
      lit_done++;
    end
  end

  task automatic post(string n, logic [31:0] a, logic [31:0] e);
    if (lit_posted < 128) begin
      lit_name[lit_posted] = n;
      lit_act[lit_posted]  = a;
      lit_exp[lit_posted]  = e;
      lit_posted++;
    end
  endtask

  task automatic drive(bit port, bit req, bit rw, bit [1:0] sz,
                       bit [7:0] a, bit [31:0] wd);
    if (port) begin
      l_req = req; l_rw = rw; l_size = sz; l_addr = a; l_wdata = wd;
    end else begin
      p_req = req; p_rw = rw; p_size = sz; p_addr = a; p_wdata = wd;
    end
  endtask

  task automatic do_req(input bit port, input bit rw, input bit [1:0] sz,
                        input bit [7:0] a, input bit [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat, output bit en_seen,
                        output int dcyc);
    drive(port, 1, rw, sz, a, wd);
    lat = 0; en_seen = 0; rd = 0; er = 0; dcyc = 0;
    while (lat < 64) begin
      @(negedge Clk);
      lat++;
      if (m_en) en_seen = 1;
      if (port ? l_done : p_done) begin
        rd = port ? l_rdata : p_rdata;
        er = port ? l_err : p_err;
        dcyc = cyc;
        drive(port, 0, rw, sz, a, wd);
        return;
      end
    end
    post("done_timeout", 32'(lat), 0);
    drive(port, 0, rw, sz, a, wd);
  endtask

  task automatic rand_req(bit port);
    bit [1:0] sz;
    bit [7:0] a;
    sz = 2'($urandom_range(3, 0));
    a  = 8'($urandom);
    if ($urandom_range(3, 0) != 0) begin
      if (sz == 2'b10) a[0] = 1'b0;
      if (sz == 2'b01) a[1:0] = 2'b00;
    end
    drive(port, 1, 1'($urandom_range(1, 0)), sz, a, $urandom);
  endtask

  task automatic rand_drive(input bit port, input int ncyc);
    bit active;
    int w;
    active = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge Clk);
      if (active && (port ? l_done : p_done)) begin
        if ($urandom_range(1, 0) == 1) rand_req(port);
        else begin
          if (port) l_req = 0; else p_req = 0;
          active = 0;
        end
      end else if (!active && $urandom_range(2, 0) == 0) begin
        rand_req(port);
        active = 1;
      end
    end
    w = 0;
    while (active && w < 100) begin
      @(negedge Clk);
      w++;
      if (port ? l_done : p_done) begin
        if (port) l_req = 0; else p_req = 0;
        active = 0;
      end
    end
    if (active) post("drain_timeout", 32'(w), 0);
  endtask

  logic [31:0] rd, rd2;
  logic        er, er2;
  int          lat, lat2, dc, dc2, pcnt, pc_at;
  bit          ens, ens2;
  logic [3:0]  st;
  bit [1:0]    esz [3];
  bit [7:0]    ead [3];

  initial begin
    Reset = 1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(negedge Clk);
    post("rst_m_en", 32'(m_en), 0);
    post("rst_m_addr", 32'(m_addr), 0);
    post("rst_m_wdata", 32'(m_wdata), 0);
    post("rst_busy", 32'(busy), 0);
    post("rst_rdata", p_rdata | l_rdata, 0);
    Reset = 0;
    @(negedge Clk);

    do_req(0, 1, 2'b01, 8'h10, 32'h11223344, rd, er, lat, ens, dc);
    post("ww_latency", 32'(lat), 5);
    post("ww_mem", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'h11223344);
    @(negedge Clk);
    do_req(0, 0, 2'b01, 8'h10, 0, rd, er, lat, ens, dc);
    post("wr_rdata", rd, 32'h11223344);

    @(negedge Clk);
    fork
      do_req(0, 0, 2'b00, 8'h10, 0, rd, er, lat, ens, dc);
      do_req(1, 0, 2'b00, 8'h11, 0, rd2, er2, lat2, ens2, dc2);
    join
    post("sim_gap", 32'(dc2 - dc), 3);
    post("sim_p_rd", rd, 32'h11);
    post("sim_l_rd", rd2, 32'h22);

    @(negedge Clk);
    pcnt = 0;
    fork
      for (int k = 0; k < 5; k++) begin
        do_req(0, 0, 2'b00, 8'(k), 0, rd, er, lat, ens, dc);
        pcnt++;
      end
      begin
        do_req(1, 0, 2'b00, 8'h20, 0, rd2, er2, lat2, ens2, dc2);
        pc_at = pcnt;
        st = dut.starve_cnt;
      end
    join
    post("starve_p_before_l", 32'(pc_at), 4);
    post("starve_cnt_clr", 32'(st), 0);

    esz[0] = 2'b01; ead[0] = 8'h02;
    esz[1] = 2'b10; ead[1] = 8'h05;
    esz[2] = 2'b11; ead[2] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      do_req(0, 0, esz[k], ead[k], 0, rd, er, lat, ens, dc);
      post("inv_err", 32'(er), 1);
      post("inv_latency", 32'(lat), 1);
      post("inv_no_beat", 32'(ens), 0);
    end

    @(negedge Clk);
    do_req(1, 1, 2'b10, 8'hFE, 32'h0000ABCD, rd, er, lat, ens, dc);
    @(negedge Clk);
    do_req(0, 0, 2'b10, 8'hFE, 0, rd, er, lat, ens, dc);
    post("hw_fe_rdata", rd, 32'h0000ABCD);
    post("hw_fe_err", 32'(er), 0);
    @(negedge Clk);
    do_req(0, 0, 2'b01, 8'hFC, 0, rd, er, lat, ens, dc);
    post("w_fc_rdata", rd, 32'h0000ABCD);
    @(negedge Clk);
    do_req(0, 1, 2'b00, 8'hFF, 32'h5A, rd, er, lat, ens, dc);
    @(negedge Clk);
    do_req(0, 0, 2'b00, 8'hFF, 0, rd, er, lat, ens, dc);
    post("b_ff_rdata", rd, 32'h0000005A);

    @(negedge Clk);
    drive(0, 1, 1, 2'b01, 8'h40, 32'hDEADBEEF);
    repeat (2) @(negedge Clk);
    Reset = 1;
    p_req = 0;
    @(negedge Clk);
    Reset = 0;
    post("rst_mid_m_en", 32'(m_en), 0);
    post("rst_mid_busy", 32'(busy), 0);
    post("rst_mid_done", 32'(p_done), 0);
    post("rst_mid_mem", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]},
         32'hDEAD0000);

    @(negedge Clk);
    fork
      rand_drive(0, 3000);
      rand_drive(1, 3000);
    join
    repeat (5) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

- Shares the single byte-wide data-memory port between two requesters: the pipeline MEM stage (port P) and the test/loader port (port L).
- Breaks each byte, halfword or word request into sequential byte beats in big-endian order, MSB at the lowest address.
- Returns assembled read data on a one-cycle done pulse.
- Gives the pipeline fixed priority, with a starvation counter that guarantees the loader forward progress.

## Interface
Parameters:
- STARVE_LIMIT, default 4: consecutive lost arbitrations after which port L wins; range 1–15.

Ports:
- Clk  in  1  clock; all state changes on the rising edge
- Reset  in  1  synchronous, active-high reset
- p_req, l_req  in  1  request, held until the matching done
- p_rw, l_rw  in  1  1 = write, 0 = read
- p_size, l_size  in  2  00 = byte, 10 = halfword, 01 = word, 11 = reserved
- p_addr, l_addr  in  8  byte address
- p_wdata, l_wdata  in  32  write data, right-justified for byte/halfword
- p_done, l_done  out  1  one-cycle completion pulse
- p_err, l_err  out  1  valid with done; 1 = misaligned or reserved size
- p_rdata, l_rdata  out  32  read result, zero-extended, held until that port's next done
- m_en  out  1  memory beat strobe
- m_we  out  1  memory write enable for this beat
- m_addr  out  8  memory byte address
- m_wdata  out  8  memory write byte
- m_rdata  in  8  memory read byte, combinational from m_addr
- busy  out  1  state ≠ IDLE

## Operation
State machine: IDLE, XFER, RESP.

IDLE:
- At an edge with p_req or l_req high, arbitrate.
- Latch winner, rw, size, addr and wdata; clear beat counter.
- Go to XFER, or go straight to RESP with err = 1 if the request is invalid.

Arbitration:
- Port P wins by default.
- Port L wins if p_req = 0, or if starve_cnt == STARVE_LIMIT.
- starve_cnt (4 bits) increments at each IDLE edge where l_req = 1 and port P wins.
- starve_cnt clears when port L is granted.
- starve_cnt saturates at STARVE_LIMIT.

Invalid requests:
- size 11.
- Halfword with addr[0] = 1.
- Word with addr[1:0] ≠ 00.
- An invalid request causes no memory beat.

Beat counts: byte = 1, halfword = 2, word = 4.

XFER, for beat b:
- m_en = 1, m_we = rw.
- m_addr = addr + b, modulo 256.
- m_wdata = byte (N−1−b) of the right-justified wdata.
- Reads shift m_rdata into the assembly register at each edge.
- At the edge where b = N−1, go to RESP.

RESP:
- Assert done and err for the granted port only; rdata is updated on that port at this time.
- Go to IDLE at the next edge.
- Requesters must drop req, or present a new request, in the cycle after done.
- A req still high in the following IDLE cycle is treated as a new request.

Reset values: state IDLE; m_en = 0, m_we = 0, m_addr = 0, m_wdata = 0; all done/err = 0; p_rdata = 0, l_rdata = 0; starve_cnt = 0; busy = 0.

Reset mid-XFER:
- Return to IDLE immediately; remaining beats are abandoned.
- Bytes already written stay written.
- No done pulse is issued.

In IDLE or RESP, m_en and m_we are 0.

## Timing
- Request accepted at IDLE edge t. Beats occupy cycles t+1 … t+N. done is high in cycle t+N+1. The next acceptance is possible at the edge ending cycle t+N+2, which is an IDLE cycle.
- Word access: 6 cycles from acceptance to a free port. Byte access: 3 cycles.
- Invalid request: done with err in cycle t+1.
- Requester inputs are sampled only at the acceptance edge; later changes are ignored.
- Request inputs of the losing port are never latched. That port keeps req high until its own done.
- Read data for the final beat is taken from m_rdata in cycle t+N. rdata is valid together with done.

## Test plan
- **Word write, then read:** port P writes word 0x11223344 to 0x10, then reads 0x10.
  - Beats go to addresses 10, 11, 12, 13 with data 11, 22, 33, 44.
  - p_done is high 5 cycles after acceptance.
  - The read returns p_rdata = 0x11223344.
- **Simultaneous requests:** p_req and l_req rise together.
  - Port P is served first and port L second.
  - l_done arrives only after p_done plus one IDLE cycle.
- **Starvation, STARVE_LIMIT = 4:** port P re-requests continuously while l_req is held.
  - Port L is granted on the 5th arbitration.
  - starve_cnt then reads 0.
- **Alignment and size errors:**
  - Word at 0x02: done and err = 1 in cycle t+1, m_en never high.
  - Halfword at 0x05: same response.
  - Size 11: same response.
  - Halfword at 0xFE reads bytes 0xAB and 0xCD: rdata = 0x0000ABCD, err = 0.
- **Top-of-memory and byte access:**
  - Word at 0xFC accesses FC, FD, FE, FF.
  - Byte write 0x5A to 0xFF, then byte read: rdata = 0x0000005A.
- **Reset mid-operation:** assert Reset during beat 2 of a word write.
  - Next cycle: m_en = 0, busy = 0, no done.
  - Bytes at addr and addr+1 are written; addr+2 and addr+3 are unchanged.
